// File: rtl/ym_phase_sched.sv
// Master phase sequencer: splits MCLK into non-overlapping c1/c2 enables, tracks the
// slot occupying the shift registers, and schedules the debug-chain load and shift-out.
module ym_phase_sched #(
  parameter int PH_LEN   = 6,
  parameter int SLOTS    = 24,
  parameter int SLOT_W   = 5,
  parameter int DBG_SLOT = 0,
  parameter int DBG_LEN  = 16
) (
  input  logic              MCLK,
  input  logic              rst,
  input  logic              en,
  input  logic              ic_sync,
  input  logic              dbg_req,
  output logic              c1,
  output logic              c2,
  output logic              cyc_end,
  output logic [SLOT_W-1:0] slot,
  output logic              slot_last,
  output logic              dbg_load,
  output logic              dbg_busy,
  output logic              dbg_done
);

  localparam int CYC_LEN = 2 * PH_LEN;
  localparam int PH_W    = $clog2(CYC_LEN);
  localparam int CNT_W   = (DBG_LEN > 1) ? $clog2(DBG_LEN) : 1;

  localparam logic [PH_W-1:0]   PH_C1_LAST  = PH_W'(PH_LEN - 2);
  localparam logic [PH_W-1:0]   PH_C2_FIRST = PH_W'(PH_LEN);
  localparam logic [PH_W-1:0]   PH_C2_LAST  = PH_W'(CYC_LEN - 2);
  localparam logic [PH_W-1:0]   PH_LAST     = PH_W'(CYC_LEN - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_DBG    = SLOT_W'(DBG_SLOT);
  localparam logic [CNT_W-1:0]  CNT_INIT    = CNT_W'(DBG_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_SHIFT = 2'd3;

  logic [PH_W-1:0]  ph_cnt_p0;
  logic [1:0]       st_p0;
  logic [1:0]       st_nxt;
  logic [CNT_W-1:0] dbg_cnt_p0;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_nxt;
  logic             c1_p1;
  logic             c2_p1;
  logic             done_p1;

  assign cyc_end   = en && (ph_cnt_p0 == PH_LAST);
  assign slot_last = (slot == SLOT_LAST);
  assign dbg_load  = (st_p0 == ST_LOAD);
  assign dbg_busy  = (st_p0 != ST_IDLE);
  assign c1        = c1_p1;
  assign c2        = c2_p1;
  assign dbg_done  = done_p1;

  // Readout sequencing; every transition waits for a cycle end, and a slot resync
  // abandons any readout in flight without reporting completion.
  always_comb begin
    st_nxt   = st_p0;
    cnt_nxt  = dbg_cnt_p0;
    done_nxt = 1'b0;
    if (cyc_end) begin
      case (st_p0)
        ST_IDLE: begin
          if (dbg_req) st_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (ic_sync)               st_nxt = ST_IDLE;
          else if (slot == SLOT_DBG) st_nxt = ST_LOAD;
        end
        ST_LOAD: begin
          if (ic_sync) begin
            st_nxt = ST_IDLE;
          end else begin
            cnt_nxt = CNT_INIT;
            if (DBG_LEN == 1) begin
              st_nxt   = ST_IDLE;
              done_nxt = 1'b1;
            end else begin
              st_nxt = ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (ic_sync) begin
            st_nxt = ST_IDLE;
          end else begin
            cnt_nxt = dbg_cnt_p0 - 1'b1;
            if (dbg_cnt_p0 == CNT_ONE) begin
              st_nxt   = ST_IDLE;
              done_nxt = 1'b1;
            end
          end
        end
        default: st_nxt = ST_IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: phase decode registered one MCLK behind the divider.
  always_ff @(posedge MCLK) begin
    if (!rst) begin
      ph_cnt_p0  <= '0;
      slot       <= '0;
      st_p0      <= ST_IDLE;
      dbg_cnt_p0 <= '0;
      c1_p1      <= 1'b0;
      c2_p1      <= 1'b0;
      done_p1    <= 1'b0;
    end else begin
      c1_p1      <= en && (ph_cnt_p0 <= PH_C1_LAST);
      c2_p1      <= en && (ph_cnt_p0 >= PH_C2_FIRST) && (ph_cnt_p0 <= PH_C2_LAST);
      done_p1    <= done_nxt;
      st_p0      <= st_nxt;
      dbg_cnt_p0 <= cnt_nxt;
      if (en) ph_cnt_p0 <= (ph_cnt_p0 == PH_LAST) ? '0 : ph_cnt_p0 + 1'b1;
      if (cyc_end) slot <= (ic_sync || (slot == SLOT_LAST)) ? '0 : slot + 1'b1;
    end
  end

endmodule

// File: tb/tb_ym_phase_sched.sv
// Scoreboard bench for ym_phase_sched: a behavioural model predicts every output per MCLK,
// and a negedge monitor pops and compares those predictions against the design.
module tb_ym_phase_sched;
  localparam int P  = 6;
  localparam int NS = 24;
  localparam int SW = 5;
  localparam int DS = 0;
  localparam int DL = 16;
  localparam int CL = 2 * P;

  logic          MCLK = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          ic_sync = 1'b0;
  logic          dbg_req = 1'b0;
  logic          c1, c2, cyc_end, slot_last, dbg_load, dbg_busy, dbg_done;
  logic [SW-1:0] slot;

  ym_phase_sched #(.PH_LEN(P), .SLOTS(NS), .SLOT_W(SW), .DBG_SLOT(DS), .DBG_LEN(DL)) dut (
    .MCLK(MCLK), .rst(rst), .en(en), .ic_sync(ic_sync), .dbg_req(dbg_req),
    .c1(c1), .c2(c2), .cyc_end(cyc_end), .slot(slot), .slot_last(slot_last),
    .dbg_load(dbg_load), .dbg_busy(dbg_busy), .dbg_done(dbg_done)
  );

  always #5 MCLK = ~MCLK;

  typedef struct packed {
    logic          c1;
    logic          c2;
    logic          cyc_end;
    logic [SW-1:0] slot;
    logic          slot_last;
    logic          dbg_load;
    logic          dbg_busy;
    logic          dbg_done;
  } exp_t;

  exp_t scb[$];
  exp_t mon_x;
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state: position within the internal cycle, slot, readout mode
  // (0 idle, 1 waiting for the slot, 2 running) and internal cycles left in the readout.
  int m_ph = 0, m_slot = 0, m_mode = 0, m_left = 0;
  bit m_c1 = 0, m_c2 = 0, m_done = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL timeout %s: condition not reached, got 0 required 1 (t=%0t)", name, $time);
  endtask

  task automatic model_advance(input bit r, input bit e, input bit ic, input bit rq);
    bit end_c;
    int old_slot;
    if (!r) begin
      m_ph = 0; m_slot = 0; m_mode = 0; m_left = 0;
      m_c1 = 0; m_c2 = 0; m_done = 0;
      return;
    end
    m_c1   = e && (m_ph <= P - 2);
    m_c2   = e && (m_ph >= P) && (m_ph <= CL - 2);
    m_done = 0;
    if (!e) return;
    end_c = (m_ph == CL - 1);
    m_ph  = (m_ph + 1) % CL;
    if (!end_c) return;
    old_slot = m_slot;
    m_slot   = ic ? 0 : (m_slot + 1) % NS;
    if (m_mode == 0) begin
      if (rq) m_mode = 1;
    end else if (ic) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      if (old_slot == DS) begin
        m_mode = 2;
        m_left = DL;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit ic, input bit rq);
    exp_t x;
    @(posedge MCLK);
    #1;
    rst = r; en = e; ic_sync = ic; dbg_req = rq;
    x.c1        = m_c1;
    x.c2        = m_c2;
    x.cyc_end   = e && (m_ph == CL - 1);
    x.slot      = SW'(m_slot);
    x.slot_last = (m_slot == NS - 1);
    x.dbg_load  = (m_mode == 2) && (m_left == DL);
    x.dbg_busy  = (m_mode != 0);
    x.dbg_done  = m_done;
    scb.push_back(x);
    model_advance(r, e, ic, rq);
  endtask

  // Runs until the model sits at phase ph (and slot s unless s < 0).
  task automatic run_to(input int s, input int ph, input string name);
    int n = 0;
    while (!((s < 0 || m_slot == s) && m_ph == ph)) begin
      if (n > 2 * CL * NS) begin
        timeout(name);
        return;
      end
      step(1, 1, 0, 0);
      n++;
    end
  endtask

  task automatic run_to_mode(input int mode, input int max_left, input int ph, input string name);
    int n = 0;
    while (!(m_mode == mode && m_left <= max_left && m_ph == ph)) begin
      if (n > 3 * CL * NS) begin
        timeout(name);
        return;
      end
      step(1, 1, 0, 0);
      n++;
    end
  endtask

  always @(negedge MCLK) begin
    if (scb.size() > 0) begin
      mon_x = scb.pop_front();
      check("c1", c1, mon_x.c1);
      check("c2", c2, mon_x.c2);
      check("cyc_end", cyc_end, mon_x.cyc_end);
      check("slot", int'(slot), int'(mon_x.slot));
      check("slot_last", slot_last, mon_x.slot_last);
      check("dbg_load", dbg_load, mon_x.dbg_load);
      check("dbg_busy", dbg_busy, mon_x.dbg_busy);
      check("dbg_done", dbg_done, mon_x.dbg_done);
      check("c1_c2_overlap", c1 & c2, 0);
    end
  end

  initial begin
    repeat (3) step(0, 1, 0, 0);
    repeat (CL * NS + 30) step(1, 1, 0, 0);

    // Freeze mid-c1 and resume.
    run_to(-1, 2, "en_low_mid_c1");
    repeat (5) step(1, 0, 0, 0);
    repeat (2 * CL) step(1, 1, 0, 0);

    // Resync at a cycle end with slot 9, then away from a cycle end.
    run_to(9, CL - 1, "slot9_end");
    step(1, 1, 1, 0);
    repeat (CL) step(1, 1, 0, 0);
    run_to(-1, 3, "mid_cycle");
    step(1, 1, 1, 0);
    repeat (2 * CL) step(1, 1, 0, 0);

    // Full readout requested while slot 5.
    run_to(5, CL - 1, "req_slot5");
    step(1, 1, 0, 1);
    repeat (CL * (NS + DL + 4)) step(1, 1, 0, 0);

    // Reset during SHIFT.
    run_to(-1, CL - 1, "req_for_rst");
    step(1, 1, 0, 1);
    run_to_mode(2, DL - 3, 4, "reach_shift");
    repeat (2) step(0, 1, 0, 0);
    repeat (3 * CL) step(1, 1, 0, 0);

    // Resync during LOAD.
    run_to(-1, CL - 1, "req_for_ic");
    step(1, 1, 0, 1);
    run_to_mode(2, DL, CL - 1, "reach_load_end");
    step(1, 1, 1, 0);
    repeat (3 * CL) step(1, 1, 0, 0);

    // Held request re-arms back to back.
    repeat (CL * 60) step(1, 1, 0, 1);

    // Randomised traffic.
    repeat (5000) begin
      bit r, e, ic, rq;
      r  = ($urandom_range(0, 1499) != 0);
      e  = ($urandom_range(0, 9) != 0);
      ic = ($urandom_range(0, 39) == 0);
      rq = ($urandom_range(0, 3) == 0);
      step(r, e, ic, rq);
    end

    @(negedge MCLK);
    #1;
    check("scoreboard_drained", scb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
